// File: rtl/apb_memif_bridge.sv
// APB4 completer that forwards each transfer as one registered request on the
// UART memory-request interface, with error mapping and a bounded timeout.
module apb_memif_bridge #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o,
  output logic                    mreq_o,
  output logic [ADDR_WIDTH-1:0]   maddr_o,
  output logic                    mwe_o,
  output logic [DATA_WIDTH-1:0]   mwdata_o,
  output logic [DATA_WIDTH/8-1:0] mstrb_o,
  input  logic                    mack_i,
  input  logic [DATA_WIDTH-1:0]   mrdata_i,
  input  logic                    mresp_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      TIMEOUT_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    mreq_q, mreq_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic                    mwe_q, mwe_d;
  logic [DATA_WIDTH-1:0]   mwdata_q, mwdata_d;
  logic [STRB_WIDTH-1:0]   mstrb_q, mstrb_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic setup_phase;
  logic timeout_hit;

  assign setup_phase = psel_i & ~penable_i;
  // cnt_q counts REQ edges already passed without an acknowledge
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      mreq_q    <= 1'b0;
      maddr_q   <= '0;
      mwe_q     <= 1'b0;
      mwdata_q  <= '0;
      mstrb_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mreq_q    <= mreq_d;
      maddr_q   <= maddr_d;
      mwe_q     <= mwe_d;
      mwdata_q  <= mwdata_d;
      mstrb_q   <= mstrb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (setup_phase) state_d = REQ;
      REQ: begin
        if (!psel_i)          state_d = IDLE;
        else if (mack_i)      state_d = DONE;
        else if (timeout_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mreq_d    = mreq_q;
    maddr_d   = maddr_q;
    mwe_d     = mwe_q;
    mwdata_d  = mwdata_q;
    mstrb_d   = mstrb_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup_phase) begin
          maddr_d  = paddr_i;
          mwe_d    = pwrite_i;
          mwdata_d = pwdata_i;
          mstrb_d  = pwrite_i ? pstrb_i : '0;
          mreq_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      REQ: begin
        if (!psel_i) begin
          // bus master abandoned the transfer: withdraw without responding
          mreq_d   = 1'b0;
          pready_d = 1'b0;
        end else if (mack_i) begin
          prdata_d  = mwe_q ? '0 : mrdata_i;
          pslverr_d = mresp_i;
          mreq_d    = 1'b0;
          pready_d  = 1'b1;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (timeout_hit) begin
            mreq_d    = 1'b0;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end
        end
      end
      DONE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
      default: begin
        mreq_d   = 1'b0;
        pready_d = 1'b0;
      end
    endcase
  end

  assign pready_o  = pready_q;
  assign prdata_o  = prdata_q;
  assign pslverr_o = pslverr_q;
  assign mreq_o    = mreq_q;
  assign maddr_o   = maddr_q;
  assign mwe_o     = mwe_q;
  assign mwdata_o  = mwdata_q;
  assign mstrb_o   = mstrb_q;

endmodule

// File: tb/tb_apb_memif_bridge.sv
// Directed plus randomized APB transfers against a cycle-count reference model
// and a byte-strobed memory responder living in the bench.
module tb_apb_memif_bridge;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TIMEOUT = 16;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic          psel_i, penable_i, pwrite_i;
  logic [AW-1:0] paddr_i;
  logic [DW-1:0] pwdata_i;
  logic [SW-1:0] pstrb_i;
  logic          pready_o, pslverr_o;
  logic [DW-1:0] prdata_o;
  logic          mreq_o, mwe_o;
  logic [AW-1:0] maddr_o;
  logic [DW-1:0] mwdata_o;
  logic [SW-1:0] mstrb_o;
  logic          mack_i, mresp_i;
  logic [DW-1:0] mrdata_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [8];

  apb_memif_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .psel_i   (psel_i),
    .penable_i(penable_i),
    .paddr_i  (paddr_i),
    .pwrite_i (pwrite_i),
    .pwdata_i (pwdata_i),
    .pstrb_i  (pstrb_i),
    .pready_o (pready_o),
    .prdata_o (prdata_o),
    .pslverr_o(pslverr_o),
    .mreq_o   (mreq_o),
    .maddr_o  (maddr_o),
    .mwe_o    (mwe_o),
    .mwdata_o (mwdata_o),
    .mstrb_o  (mstrb_o),
    .mack_i   (mack_i),
    .mrdata_i (mrdata_i),
    .mresp_i  (mresp_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // One complete APB transfer starting at a negedge; the responder acks in
  // REQ cycle number 'delay' (0 = first), or never if delay >= TIMEOUT.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input int delay, input bit resp,
                      input string tag);
    bit            timed_out;
    int            exp_mreq, nreq, cycles;
    logic [DW-1:0] rd_val, exp_rdata;
    logic          exp_err;
    logic [63:0]   exp_fields;
    timed_out  = (delay >= TIMEOUT);
    exp_mreq   = timed_out ? TIMEOUT : delay + 1;
    rd_val     = mem[addr[4:2]];
    exp_rdata  = (timed_out || wr) ? '0 : rd_val;
    exp_err    = timed_out ? 1'b1 : resp;
    exp_fields = {21'd0, addr, wr, wdata, (wr ? strb : 4'h0)};

    psel_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwrite_i = wr;
    pwdata_i = wdata; pstrb_i = strb;
    cyc();
    penable_i = 1'b1;
    cycles = 2;
    nreq = 0;
    while (!pready_o && nreq < 40) begin
      chk({tag, "_mreq_hi"}, mreq_o, 1'b1);
      chk({tag, "_fields"}, {21'd0, maddr_o, mwe_o, mwdata_o, mstrb_o}, exp_fields);
      if (nreq == delay) begin
        mack_i = 1'b1; mrdata_i = rd_val; mresp_i = resp;
      end else begin
        mack_i = 1'b0; mrdata_i = $urandom; mresp_i = 1'($urandom);
      end
      nreq++;
      cyc();
      cycles++;
    end
    mack_i = 1'b0;
    chk({tag, "_mreq_cycles"}, nreq, exp_mreq);
    chk({tag, "_apb_cycles"}, cycles, exp_mreq + 2);
    chk({tag, "_pready"}, pready_o, 1'b1);
    chk({tag, "_mreq_lo_at_ready"}, mreq_o, 1'b0);
    chk({tag, "_pslverr"}, pslverr_o, exp_err);
    chk({tag, "_prdata"}, prdata_o, exp_rdata);
    $display("xfer %s wr=%0b addr=%0h delay=%0d resp=%0b -> pready cycle %0d err=%0b rdata=%0h",
             tag, wr, addr, delay, resp, cycles, pslverr_o, prdata_o);
    if (wr && !timed_out && !resp) begin
      for (int b = 0; b < SW; b++)
        if (strb[b]) mem[addr[4:2]][8*b +: 8] = wdata[8*b +: 8];
    end
    cyc();
    chk({tag, "_pready_clr"}, pready_o, 1'b0);
    chk({tag, "_pslverr_clr"}, pslverr_o, 1'b0);
    chk({tag, "_mreq_gap"}, mreq_o, 1'b0);
    chk({tag, "_prdata_hold"}, prdata_o, exp_rdata);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  initial begin
    int delay;
    bit wr, resp;
    arst_ni = 1'b0;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    mack_i = 1'b0; mresp_i = 1'b0; mrdata_i = '0;
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    mem[1] = 32'h0000_2580;

    #1;
    chk("reset_outputs",
        {mreq_o, mwe_o, pready_o, pslverr_o, maddr_o, mstrb_o, 1'b0},
        64'd0);
    chk("reset_data", {mwdata_o, prdata_o}, 64'd0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    cyc();

    // write then back-to-back read with three wait states
    xfer(1'b1, 5'h00, 32'h1, 4'hF, 0, 1'b0, "write0");
    xfer(1'b0, 5'h04, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, "read4");

    // error mapping, then a clean transfer
    xfer(1'b0, 5'h1C, 32'h0, 4'h0, 0, 1'b1, "err_read");
    xfer(1'b0, 5'h00, 32'h0, 4'h0, 1, 1'b0, "after_err");

    // timeout, then a late acknowledge that must be ignored
    xfer(1'b0, 5'h08, 32'h0, 4'h0, 99, 1'b0, "timeout");
    mack_i = 1'b1; mresp_i = 1'b1; mrdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("late_ack_mreq", mreq_o, 1'b0);
      chk("late_ack_pready", {pready_o, pslverr_o}, 2'b00);
    end
    mack_i = 1'b0;

    // abort by dropping psel in REQ
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 5'h08; pwrite_i = 1'b0;
    cyc();
    chk("abort_req", mreq_o, 1'b1);
    psel_i = 1'b0; penable_i = 1'b0;
    cyc();
    chk("abort_mreq", mreq_o, 1'b0);
    chk("abort_pready", pready_o, 1'b0);
    mack_i = 1'b1;
    cyc();
    chk("abort_late_ack", {mreq_o, pready_o}, 2'b00);
    mack_i = 1'b0;
    cyc();
    $display("abort checked");
    xfer(1'b1, 5'h0C, 32'hA5A5_5A5A, 4'h5, 2, 1'b0, "post_abort");

    // asynchronous reset during REQ
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 5'h10; pwrite_i = 1'b1;
    pwdata_i = 32'h1234_5678; pstrb_i = 4'hF;
    cyc();
    penable_i = 1'b1;
    chk("rst_req_mreq", mreq_o, 1'b1);
    arst_ni = 1'b0;
    #1;
    chk("async_rst_mreq", mreq_o, 1'b0);
    chk("async_rst_pready", pready_o, 1'b0);
    chk("async_rst_maddr", maddr_o, 5'h00);
    @(negedge clk_i);
    arst_ni = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
    cyc();
    $display("async reset checked");
    xfer(1'b0, 5'h0C, 32'h0, 4'h0, 0, 1'b0, "post_reset");

    // randomized transfers
    for (int t = 0; t < 30; t++) begin
      wr    = 1'($urandom);
      resp  = ($urandom_range(0, 7) == 0);
      delay = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                          : int'($urandom_range(0, 4));
      xfer(wr, {3'($urandom), 2'b00}, $urandom, 4'($urandom), delay, resp,
           $sformatf("rand%0d", t));
      if ($urandom_range(0, 1) == 1) cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_memif_bridge.md
# apb_memif_bridge

APB4 completer that turns each APB transfer into exactly one request on the UART's internal memory-request interface (mreq/maddr/mwe/mwdata/mstrb -> mack/mrdata/mresp) and waits for the register file to respond. It sits between the external APB bus and the UART register interface. It registers all request fields, holds the request stable until acknowledged, maps a memory error to PSLVERR, and ends a hung request with a bounded timeout.

## Interface
- ADDR_WIDTH, 5: APB and memory address width (bytes)
- DATA_WIDTH, 32: data width; strobe width DATA_WIDTH/8
- TIMEOUT_CYCLES, 16: maximum number of cycles mreq_o may stay high without mack_i; 0 disables the timeout
- clk_i  in  1  clock
- arst_ni  in  1  reset, asynchronous, active-low
- psel_i  in  1  APB select
- penable_i  in  1  APB access phase
- paddr_i  in  ADDR_WIDTH  APB address
- pwrite_i  in  1  APB write
- pwdata_i  in  DATA_WIDTH  APB write data
- pstrb_i  in  DATA_WIDTH/8  APB write strobes
- pready_o  out  1  APB ready
- prdata_o  out  DATA_WIDTH  APB read data
- pslverr_o  out  1  APB error
- mreq_o  out  1  memory request
- maddr_o  out  ADDR_WIDTH  memory address
- mwe_o  out  1  memory write enable
- mwdata_o  out  DATA_WIDTH  memory write data
- mstrb_o  out  DATA_WIDTH/8  memory byte strobe
- mack_i  in  1  memory acknowledge
- mrdata_i  in  DATA_WIDTH  memory read data, valid when mack_i is high
- mresp_i  in  1  memory error, valid when mack_i is high

## Operation
- FSM has three states: IDLE, REQ, DONE. All outputs are driven from registers.
- Reset values: state IDLE; mreq_o, mwe_o, pready_o, pslverr_o are 0; maddr_o, mwdata_o, mstrb_o, prdata_o are 0; timeout counter is 0.
- **IDLE**
  - On a setup phase (psel_i=1, penable_i=0), capture paddr_i->maddr_o and pwrite_i->mwe_o.
  - Capture pwdata_i->mwdata_o.
  - Capture pstrb_i->mstrb_o on a write; on a read, mstrb_o = 0.
  - Set mreq_o=1, clear the counter, and go to REQ.
- **REQ**
  - mreq_o and all request fields are held stable.
  - If mack_i=1: capture prdata_o = mrdata_i on a read (0 on a write) and pslverr_o = mresp_i. Drop mreq_o, set pready_o=1, and go to DONE.
  - Otherwise, increment the counter. When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with no mack_i, the request times out: drop mreq_o, set pready_o=1, pslverr_o=1, prdata_o=0, and go to DONE.
- **DONE**
  - pready_o=1 for exactly one cycle. The transfer completes at this edge.
  - Clear pready_o and pslverr_o, then go to IDLE. prdata_o keeps its value until the next capture.
- **Abort:** psel_i=0 in REQ or DONE is an APB protocol violation. Drop mreq_o and pready_o and go to IDLE; no response is issued. A mack_i arriving after the abort is ignored.
- mack_i, mrdata_i, and mresp_i are ignored outside REQ.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1; it saturates and never wraps.
- Asynchronous reset mid-transfer forces reset values immediately; the interrupted request is dropped.

## Timing
- **Edge numbering:** E0 is the edge that samples the setup phase. mreq_o is high from after E0.
- **Earliest completion:** if mack_i is high at E1, pready_o is high after E1 and the transfer completes at E2.
  - Minimum APB transfer is 3 cycles: setup, one wait state, completion.
  - Each cycle of mack_i delay adds one wait state.
- mreq_o is high for at least 1 and at most TIMEOUT_CYCLES cycles when the timeout is enabled.
- **Back-to-back transfers:**
  - A new setup phase can be sampled at the edge after DONE.
  - Throughput is one transfer per 3 cycles at minimum.
  - The bridge never issues a new mreq_o in the cycle pready_o is high.
- mack_i is sampled only at a clock edge in REQ. A combinational same-cycle acknowledge from the register file is legal.

## Test plan
- **Write:** setup write paddr=0x00, pwdata=0x1, pstrb=0xF; responder acks on the first REQ cycle -> mreq_o high 1 cycle with maddr_o=0x00, mwe_o=1, mwdata_o=0x1, mstrb_o=0xF; pready_o high in the 3rd APB cycle with pslverr_o=0.
- **Read with wait states:** read paddr=0x04; mack_i delayed 3 cycles with mrdata_i=0x2580 -> mstrb_o=0; mreq_o high for 4 cycles; prdata_o=0x2580; pslverr_o=0; the transfer takes 6 APB cycles.
- **Error mapping:** read of an unmapped address; responder gives mack_i=1 with mresp_i=1 -> pslverr_o=1 together with pready_o; the next transfer shows pslverr_o=0.
- **Timeout:** TIMEOUT_CYCLES=16, mack_i is never asserted -> mreq_o high for exactly 16 cycles; then pready_o=1, pslverr_o=1, prdata_o=0. A late mack_i asserted afterwards is ignored.
- **Back-to-back:** a write to 0x00 followed immediately by a read of 0x04 -> two separate mreq_o pulses with mreq_o low between them; each transfer completes in 3 cycles.
- **Abort and reset:** drop psel_i in REQ -> mreq_o is 0 next cycle and the FSM returns to IDLE. Assert arst_ni in REQ -> mreq_o and pready_o go 0 asynchronously, and a fresh transfer works normally after release.
